// File: rtl/minmax_if.sv
// Handshake and result bundle for the min/max tracker: burst control, sample stream,
// and the registered results of the last burst.
interface minmax_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
);
   logic             energy;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic             empty;
   logic [WIDTH-1:0] min_out;
   logic [WIDTH-1:0] max_out;
   logic [CNT_W-1:0] min_idx;
   logic [CNT_W-1:0] max_idx;

   modport master (
      output energy, start, len, in_valid, in_data,
      input  in_ready, busy, done, empty, min_out, max_out, min_idx, max_idx
   );

   modport slave (
      input  energy, start, len, in_valid, in_data,
      output in_ready, busy, done, empty, min_out, max_out, min_idx, max_idx
   );
endinterface

// File: rtl/minmax_tracker.sv
// Burst min/max tracker: consumes len signed samples and reports the extreme values
// and the index of their first occurrence, using the ALU's overflow-corrected compare.
module minmax_tracker #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input logic     clk,
   input logic     rst,
   minmax_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state, state_nxt;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_inc;
   logic [WIDTH-1:0] min_q, max_q;
   logic [CNT_W-1:0] min_idx_q, max_idx_q;
   logic             empty_q;
   logic             in_ready;
   logic             accept;

   // Same rule as the ALU comparator: sign of (a - b) flipped when the subtraction overflows.
   function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] d;
      logic             ovf;
      d   = a - b;
      ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (d[WIDTH-1] ^ a[WIDTH-1]);
      return d[WIDTH-1] ^ ovf;
   endfunction

   assign count_inc = count + CNT_W'(1);
   assign accept    = in_ready & bus.in_valid;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.energy && bus.start)
               state_nxt = (bus.len == '0) ? DONE : RUN;
         end
         RUN: begin
            bus.busy = 1'b1;
            in_ready = bus.energy;
            if (accept && count_inc == len_q) state_nxt = DONE;
         end
         DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
            if (bus.energy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q     <= '0;
         count     <= '0;
         min_q     <= '0;
         max_q     <= '0;
         min_idx_q <= '0;
         max_idx_q <= '0;
         empty_q   <= 1'b0;
      end else if (state == IDLE && bus.energy && bus.start) begin
         len_q <= bus.len;
         count <= '0;
         if (bus.len == '0) begin
            min_q     <= MAX_POS;
            max_q     <= MIN_NEG;
            min_idx_q <= '0;
            max_idx_q <= '0;
            empty_q   <= 1'b1;
         end else begin
            empty_q <= 1'b0;
         end
      end else if (accept) begin
         count <= count_inc;
         if (count == '0) begin
            min_q     <= bus.in_data;
            max_q     <= bus.in_data;
            min_idx_q <= '0;
            max_idx_q <= '0;
         end else begin
            // Strict compares keep the earliest index on ties.
            if (less_than(bus.in_data, min_q)) begin
               min_q     <= bus.in_data;
               min_idx_q <= count;
            end
            if (less_than(max_q, bus.in_data)) begin
               max_q     <= bus.in_data;
               max_idx_q <= count;
            end
         end
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.empty    = empty_q;
   assign bus.min_out  = min_q;
   assign bus.max_out  = max_q;
   assign bus.min_idx  = min_idx_q;
   assign bus.max_idx  = max_idx_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Scoreboard bench for minmax_tracker: directed bursts push expected results at start,
// a monitor pops and compares on each done pulse and checks its width.
module tb_minmax_tracker;

   localparam int WIDTH = 16;
   localparam int CNT_W = 8;

   typedef struct {
      logic [WIDTH-1:0] mn;
      logic [WIDTH-1:0] mx;
      logic [CNT_W-1:0] mni;
      logic [CNT_W-1:0] mxi;
      logic             emp;
      int               w;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   accepts = 0;
   int   dwidth = 0;
   exp_t sb[$];
   exp_t cur;

   minmax_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   minmax_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare on the first done cycle, check pulse width when done drops.
   always @(negedge clk) begin
      if (rst) begin
         dwidth = 0;
      end else begin
         if (bus.in_valid && bus.in_ready) accepts++;
         if (bus.done) begin
            if (dwidth == 0) begin
               check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
               if (sb.size() != 0) begin
                  cur = sb.pop_front();
                  check("min", {bus.min_out, bus.min_idx}, {cur.mn, cur.mni});
                  check("max", {bus.max_out, bus.max_idx}, {cur.mx, cur.mxi});
                  check("empty", 64'(bus.empty), 64'(cur.emp));
               end
            end
            dwidth++;
         end else if (dwidth != 0) begin
            check("done_width", 64'(dwidth), 64'(cur.w));
            dwidth = 0;
         end
      end
   end

   task automatic expect_result(input logic [WIDTH-1:0] mn, input logic [CNT_W-1:0] mni,
                                input logic [WIDTH-1:0] mx, input logic [CNT_W-1:0] mxi,
                                input logic emp, input int w);
      exp_t e;
      e.mn = mn; e.mni = mni; e.mx = mx; e.mxi = mxi; e.emp = emp; e.w = w;
      sb.push_back(e);
   endtask

   // Called at posedge+1; leaves start low at the following posedge+1.
   task automatic do_start(input logic [CNT_W-1:0] l);
      bus.start = 1'b1;
      bus.len   = l;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Holds a sample until an edge accepts it; returns at posedge+1 after the accepting edge.
   task automatic push(input logic [WIDTH-1:0] d);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("push_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
      check("idle_after_done", 64'(bus.busy), 64'd0);
   endtask

   logic [WIDTH-1:0] hs_data [0:6];
   logic             hs_valid[0:6];
   logic             hs_en   [0:6];

   initial begin
      bus.energy = 1'b1; bus.start = 1'b0; bus.len = '0;
      bus.in_valid = 1'b0; bus.in_data = '0;
      #12;
      check("reset_outputs", {bus.busy, bus.done, bus.in_ready, bus.empty, bus.min_out,
                              bus.max_out, bus.min_idx, bus.max_idx}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic burst
      expect_result(16'hFFFD, 8'd1, 16'h000C, 8'd2, 1'b0, 1);
      do_start(8'd4);
      push(16'd5); push(16'hFFFD); push(16'd12); push(16'd0);
      check("basic_latency", 64'(bus.done), 64'd1);
      settle();

      // Extremes and ties
      expect_result(16'h8000, 8'd1, 16'h7FFF, 8'd0, 1'b0, 1);
      do_start(8'd5);
      push(16'h7FFF); push(16'h8000); push(16'h8000); push(16'h7FFF); push(16'h0000);
      settle();

      // Handshake with bubbles and energy low mid-burst
      hs_data  = '{16'd7, 16'd0, 16'hFFF8, 16'hFFF8, 16'hFFF8, 16'd0, 16'd7};
      hs_valid = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      hs_en    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      expect_result(16'hFFF8, 8'd1, 16'd7, 8'd0, 1'b0, 1);
      do_start(8'd3);
      accepts = 0;
      for (int i = 0; i < 7; i++) begin
         bus.in_valid = hs_valid[i];
         bus.in_data  = hs_data[i];
         bus.energy   = hs_en[i];
         @(negedge clk);
         check("hs_ready", 64'(bus.in_ready), 64'(hs_en[i]));
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      check("hs_done", 64'(bus.done), 64'd1);
      check("hs_accepts", 64'(accepts), 64'd3);
      settle();

      // Zero length
      expect_result(16'h7FFF, 8'd0, 16'h8000, 8'd0, 1'b1, 1);
      do_start(8'd0);
      check("zero_done", {bus.done, bus.empty}, 2'b11);
      settle();
      check("empty_held", 64'(bus.empty), 64'd1);

      // Zero length with energy low in DONE: done held until energy returns
      expect_result(16'h7FFF, 8'd0, 16'h8000, 8'd0, 1'b1, 3);
      do_start(8'd0);
      bus.energy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("done_held", 64'(bus.done), 64'd1);
      bus.energy = 1'b1;
      settle();

      // Reset mid-burst
      expect_result('0, '0, '0, '0, 1'b0, 1);
      do_start(8'd6);
      push(16'd40); push(16'd41);
      #2 rst = 1'b1;
      #1;
      check("rst_outputs", {bus.busy, bus.done, bus.in_ready, bus.empty, bus.min_out,
                            bus.max_out, bus.min_idx, bus.max_idx}, 64'd0);
      #2 rst = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      expect_result(16'h1234, 8'd0, 16'h1234, 8'd0, 1'b0, 1);
      do_start(8'd1);
      push(16'h1234);
      settle();

      // start while busy ignored, start during DONE ignored
      expect_result(16'hFF9C, 8'd1, 16'd100, 8'd0, 1'b0, 1);
      do_start(8'd3);
      push(16'd100);
      bus.start = 1'b1; bus.len = 8'd9;
      push(16'hFF9C);
      bus.start = 1'b0;
      push(16'd50);
      check("busy_start_done", 64'(bus.done), 64'd1);
      bus.start = 1'b1; bus.len = 8'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("done_start_ignored", 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
      check("still_idle", 64'(bus.busy), 64'd0);

      // Maximum burst length, count must not wrap
      expect_result(16'hFF9C, 8'd0, 16'd154, 8'd254, 1'b0, 1);
      do_start(8'd255);
      for (int i = 0; i < 255; i++) push(16'(i) - 16'd100);
      check("max_len_done", 64'(bus.done), 64'd1);
      settle();

      repeat (3) @(posedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
